// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: bus widths and FSM states.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_wdt.sv
// ACCESS-phase watchdog: counts cycles spent waiting for pready and flags
// the cycle in which the wait budget is used up.
module apb_wdt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Index of the last permitted ACCESS cycle (count starts at 0).
    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    // Count enabled cycles; hold once the limit is reached so it cannot wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

    // Expired during the final permitted ACCESS cycle, so the FSM aborts on
    // the edge that closes it unless pready arrives in that same cycle.
    always_comb begin
        expired = (count == LAST);
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: accepts one command, runs SETUP/ACCESS
// with a wait-state watchdog, and holds the response until consumed.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [APB_DATA_W-1:0] prdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [15:0]           txn_count,
    output logic [15:0]           err_count
);

    apb_state_t state;
    logic       wdt_clear;
    logic       wdt_enable;
    logic       wdt_expired;

    // Watchdog restarts while in SETUP so it reads 0 in the first ACCESS cycle.
    always_comb begin
        wdt_clear  = (state == ST_SETUP);
        wdt_enable = (state == ST_ACCESS);
    end

    apb_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (pclk),
        .rst     (preset),
        .clear   (wdt_clear),
        .enable  (wdt_enable),
        .expired (wdt_expired)
    );

    // Transfer FSM with every output registered alongside the state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            txn_count   <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready is checked first so a completion in the final
                    // permitted cycle is never reported as a timeout.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        txn_count   <= txn_count + 16'd1;
                        if (pslverr) begin
                            err_count <= err_count + 16'd1;
                        end
                        state <= ST_RESP;
                    end else if (wdt_expired) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        txn_count   <= txn_count + 16'd1;
                        err_count   <= err_count + 16'd1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master with a small behavioural APB completer.
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [15:0] txn_count;
    logic [15:0] err_count;

    apb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .txn_count   (txn_count),
        .err_count   (err_count)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural completer ----------------
    logic [31:0] mem [16];
    int          wait_states = 1;
    logic        hang = 1'b0;
    int          acc_cyc = 0;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cyc <= acc_cyc + 1;
        else                            acc_cyc <= 0;
        if (psel && penable && pready && pwrite && paddr != 32'h10)
            mem[paddr[5:2]] <= pwdata;
    end

    // Junk on pslverr/prdata whenever the response is not being qualified.
    assign pready  = psel && penable && !hang && (acc_cyc >= wait_states);
    assign pslverr = (paddr == 32'h10) || !pready;
    assign prdata  = !pready ? 32'hFFFF_FFFF :
                     (paddr == 32'h10) ? 32'hBAD0_0010 : mem[paddr[5:2]];

    // ---------------- scoreboard monitor ----------------
    always @(negedge pclk) begin
        if (!preset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("rsp_rdata", rsp_rdata, x.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, x.err});
                check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, x.to});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic e, input logic t,
                          input bit push);
        int n;
        exp_t x;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("cmd_ready_seen", {31'd0, cmd_ready}, 32'd1);
        if (push) begin
            x.rdata = exp_rd;
            x.err   = e;
            x.to    = t;
            sb.push_back(x);
        end
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until rsp_valid, recording where
    // psel/penable first appear and how many ACCESS cycles were seen.
    task automatic wait_rsp(output int lat, output int psel_lat, output int pen_lat,
                            output int acc);
        lat = 0; psel_lat = 0; pen_lat = 0; acc = 0;
        while (lat < 200) begin
            @(negedge pclk);
            lat++;
            if (rsp_valid) break;
            if (psel && psel_lat == 0) psel_lat = lat;
            if (penable && pen_lat == 0) pen_lat = lat;
            if (psel && penable) acc++;
        end
        if (!rsp_valid) check("rsp_wait_budget", 32'd0, 32'd1);
        if (rsp_ready) begin
            @(posedge pclk);
            #1;
        end
    endtask

    int lat, pl, el, acc;
    logic [31:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_counts", {txn_count, err_count}, 32'd0);
        preset = 1'b0;

        // Write with one wait state: psel N+1, penable N+2, rsp_valid N+4.
        wait_states = 1;
        do_cmd(1'b1, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("wr_psel_lat", pl, 1);
        check("wr_penable_lat", el, 2);
        check("wr_rsp_lat", lat, 4);
        check("wr_txn_count", {16'd0, txn_count}, 32'd1);
        check("wr_rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);

        // Read back.
        do_cmd(1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("rd_err_count", {16'd0, err_count}, 32'd0);

        // Slave error on 0x10.
        do_cmd(1'b0, 32'h10, 32'h0, 32'hBAD0_0010, 1'b1, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("slverr_err_count", {16'd0, err_count}, 32'd1);
        check("slverr_txn_count", {16'd0, txn_count}, 32'd3);

        // Zero wait states: minimum latency N+3.
        wait_states = 0;
        do_cmd(1'b1, 32'h4, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("min_rsp_lat", lat, 3);
        do_cmd(1'b0, 32'h4, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("min_rd_lat", lat, 3);

        // pready never arrives: 16 ACCESS cycles then timeout.
        hang = 1'b1;
        do_cmd(1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        wait_rsp(lat, pl, el, acc);
        check("to_access_cycles", acc, TO);
        check("to_rsp_lat", lat, TO + 2);
        check("to_err_count", {16'd0, err_count}, 32'd2);
        hang = 1'b0;

        // pready in the 16th ACCESS cycle wins over the timeout.
        wait_states = TO - 1;
        do_cmd(1'b0, 32'h4, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("edge_access_cycles", acc, TO);
        check("edge_txn_count", {16'd0, txn_count}, 32'd7);
        check("edge_err_count", {16'd0, err_count}, 32'd2);

        // Response back-pressure for 5 cycles.
        wait_states = 0;
        rsp_ready = 1'b0;
        do_cmd(1'b1, 32'h8, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        held = rsp_rdata;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h8;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_rdata_held", rsp_rdata, held);
            if (i < 4) @(negedge pclk);
        end
        cmd_valid = 1'b0;
        @(posedge pclk);
        #1 rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        check("bp_released", {31'd0, rsp_valid}, 32'd0);
        check("bp_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        check("bp_txn_count", {16'd0, txn_count}, 32'd8);

        // Reset while in ACCESS drops the transfer.
        hang = 1'b1;
        do_cmd(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        lat = 0;
        while (!(psel && penable) && lat < 20) begin
            @(negedge pclk);
            lat++;
        end
        check("rst_reached_access", {31'd0, psel && penable}, 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        check("rstacc_psel", {31'd0, psel}, 32'd0);
        check("rstacc_penable", {31'd0, penable}, 32'd0);
        check("rstacc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstacc_counts", {txn_count, err_count}, 32'd0);
        check("rstacc_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        preset = 1'b0;
        hang = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check("rstacc_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Normal operation resumes after reset.
        do_cmd(1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1);
        wait_rsp(lat, pl, el, acc);
        check("post_rst_txn_count", {16'd0, txn_count}, 32'd1);

        repeat (3) @(negedge pclk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready (range 2..65535).
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports pclk and preset.
REQ-003 pclk  input  1  clock; all logic on rising edge.
REQ-004 preset  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  32  target address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 psel, penable, pwrite  output  1 each  APB control.
REQ-011 paddr, pwdata  output  32 each  APB address, write data.
REQ-012 pready, pslverr  input  1 each  APB completer response.
REQ-013 prdata  input  32  APB read data.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-016 rsp_rdata  output  32  captured prdata (reads), 0 for writes and timeouts.
REQ-017 rsp_err  output  1  pslverr captured, or timeout.
REQ-018 rsp_timeout  output  1  transfer aborted by timeout.
REQ-019 txn_count, err_count  output  16 each  completed / errored transfers, wrap 0xFFFF->0.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-021 cmd_ready SHALL be 1 only in IDLE; handshake in IDLE latches cmd_write/addr/wdata and moves to SETUP.
REQ-022 SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata = latched command; next ACCESS.
REQ-023 ACCESS: psel=1, penable=1, paddr/pwrite/pwdata unchanged; wait states unlimited up to timeout.
REQ-024 pready sampled 1 in ACCESS: capture prdata (reads only), pslverr; go RESP; psel=penable=0 in RESP.
REQ-025 Timeout: counter cleared on entering ACCESS, increments each ACCESS cycle; reaching TIMEOUT_CYCLES without pready aborts to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 pready and timeout in the same cycle: pready wins, no timeout.
REQ-027 RESP: rsp_valid=1, rsp fields stable until rsp_ready; handshake returns to IDLE same edge.
REQ-028 Minimum latency: command accepted edge N -> psel at N+1 -> penable at N+2 -> rsp_valid at N+3 if pready high in first ACCESS cycle.
REQ-029 No new command accepted while busy; back-to-back transfers have at least one IDLE cycle between them.
REQ-030 txn_count increments on each RESP entry; err_count also increments when rsp_err is set.
REQ-031 pslverr/prdata SHALL be ignored outside ACCESS with pready=1.

Reset
REQ-032 preset SHALL, at the next edge from any state: state=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=rsp_timeout=0, counters=0, cmd_ready=1 from the following cycle; an in-flight transfer is dropped without a response.

Structure
REQ-033 Shared package apb_pkg SHALL hold the FSM state enum and APB_ADDR_W=32 / APB_DATA_W=32 constants.
REQ-034 Timeout counter SHALL be one sub-module apb_wdt (clear, enable, expired output).

Verification (bench with apb_slave as completer)
REQ-035 Write 0x0 data 0x12345678 -> psel at N+1, penable N+2, pready at N+3, rsp_valid at N+4, rsp_err=0, txn_count=1.
REQ-036 Then read 0x0 -> rsp_rdata=0x12345678, rsp_err=0.
REQ-037 Read 0x10 -> rsp_err=1, rsp_timeout=0, err_count=1.
REQ-038 pready tied 0, TIMEOUT_CYCLES=16 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 rsp_ready low 5 cycles after response -> rsp_valid and data held, cmd_ready=0 throughout; accepted on 6th.
REQ-040 preset asserted in ACCESS -> psel=penable=0 and rsp_valid=0 at next edge, no response issued, counters=0.
